// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and width constants for the SAR AFE emulator
package sar_pkg;
  localparam int DEF_WIDTH = 6;
  localparam int CNT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/sar_afe_checker.sv
// sar_afe_checker: compares the controller's result with the held code and counts mismatches
module sar_afe_checker
  import sar_pkg::*;
#(
  parameter int Width = DEF_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fire_i,
  input  logic [Width-1:0]     result_i,
  input  logic [Width-1:0]     hold_i,
  output logic                 match_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);
  logic same;
  assign same = result_i == hold_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      match_o   <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      match_o <= fire_i && same;
      if (fire_i && !same && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: rtl/sar_afe_emu.sv
// sar_afe_emu: sample/hold + comparator emulation of a SAR ADC analog front end.
// Result checking (match_o, err_cnt_o) exists only when SAR_AFE_CHECK_EN is defined.
module sar_afe_emu
  import sar_pkg::*;
#(
  parameter int Width = DEF_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [Width-1:0]     vin_i,
  input  logic                 sample_i,
  input  logic [Width-1:0]     dac_i,
  input  logic                 eoc_i,
  input  logic [Width-1:0]     result_i,
  output logic                 cmp_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 match_o,
  output logic [CNT_WIDTH-1:0] conv_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);
  state_e           state, state_nxt;
  logic [Width-1:0] hold;
  logic             eoc_q;
  logic             fire;
  // an abort (sample_i) always beats a simultaneous eoc edge
  assign fire = state == HOLD && eoc_i && !eoc_q && !sample_i;
  always_comb state_nxt = sample_i ? TRACK : state == TRACK ? HOLD : fire ? IDLE : state;
  assign busy_o = state == HOLD;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      hold       <= '0;
      eoc_q      <= 1'b0;
      cmp_o      <= 1'b0;
      done_o     <= 1'b0;
      conv_cnt_o <= '0;
    end else begin
      state  <= state_nxt;
      eoc_q  <= eoc_i;
      done_o <= fire;
      if (sample_i) hold <= vin_i;
      // hold is frozen on HOLD entry, so the current value is the one compared next cycle
      cmp_o <= state_nxt == HOLD && hold >= dac_i;
      if (fire) conv_cnt_o <= conv_cnt_o + 1'b1;
    end
  end
`ifdef SAR_AFE_CHECK_EN
  sar_afe_checker #(.Width(Width)) u_checker (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .fire_i   (fire),
    .result_i (result_i),
    .hold_i   (hold),
    .match_o  (match_o),
    .err_cnt_o(err_cnt_o)
  );
`else
  logic unused_result;
  assign unused_result = ^result_i;
  assign match_o       = 1'b0;
  assign err_cnt_o     = '0;
`endif
endmodule
